// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared types, constants and decode helper for priority_dec
package priority_pkg;

  // Occupancy-named states of the two-entry output buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fifo_state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  // Highest-priority code (0) maps to the MSB of the request vector.
  function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
    logic [3:0] onehot;
    onehot = 4'b1000 >> code;
    return onehot;
  endfunction

endpackage

// File: rtl/priority_dec.sv
// rtl/priority_dec.sv - 2-bit priority code decoder with 2-entry in-order output buffer
module priority_dec
  import priority_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       Y,
  input  logic             valid,
  output logic             in_ready,
  output logic [3:0]       D,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [CNT_W-1:0] count
);

  fifo_state_e      state_q, state_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake outputs come from registered state only; rst also holds off
  // acceptance so nothing is taken while the block is being cleared.
  always_comb begin
    in_ready = (state_q != ST_TWO) && !rst;
    d_valid  = (state_q != ST_EMPTY);
    D        = d_valid ? mem_q[rd_ptr_q] : 4'b0000;
    count    = count_q;
    push     = valid && in_ready;
    pop      = d_valid && d_ready;
  end

  // Next-state: pointer/storage update, occupancy transitions, saturating pop counter.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = code_to_onehot(Y);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_ONE;
      end
      ST_ONE: begin
        if (push && !pop)      state_d = ST_TWO;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_TWO: begin
        if (pop) state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State registers; reset empties the buffer and clears the delivery count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      mem_q[0] <= 4'b0000;
      mem_q[1] <= 4'b0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/priority_dec.md
PRIORITY_DEC -- requirements
Module: priority_dec

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the decode-event counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Y, input, 2 bits: priority code to decode.
REQ-005 SHALL have port valid, input, 1 bit: Y is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts Y this cycle.
REQ-007 SHALL have port D, output, 4 bits: one-hot decoded request vector.
REQ-008 SHALL have port d_valid, output, 1 bit: D holds a decoded entry.
REQ-009 SHALL have port d_ready, input, 1 bit: consumer takes D this cycle.
REQ-010 SHALL have port count, output, CNT_W bits: number of entries delivered, saturating.

Function
REQ-011 SHALL decode Y=0 -> 4'b1000, Y=1 -> 4'b0100, Y=2 -> 4'b0010, Y=3 -> 4'b0001 (D = 4'b1000 >> Y).
REQ-012 SHALL buffer decoded entries in a 2-entry in-order FIFO; states EMPTY, ONE, TWO by occupancy.
REQ-013 SHALL define push = valid && in_ready and pop = d_valid && d_ready.
REQ-014 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in TWO, from registered state only; in_ready SHALL NOT depend combinationally on d_ready.
REQ-015 SHALL drive d_valid = 1 in ONE and TWO; D SHALL show the oldest entry and SHALL be 4'b0000 whenever d_valid = 0.
REQ-016 SHALL have latency 1: a push in EMPTY gives d_valid = 1 with the decoded D on the next cycle.
REQ-017 SHALL transition EMPTY -> ONE on push; ONE -> TWO on push without pop; ONE -> EMPTY on pop without push.
REQ-018 SHALL transition TWO -> ONE on pop.
REQ-019 SHALL stay in ONE on simultaneous push and pop; the new entry SHALL appear on D the next cycle.
REQ-020 SHALL hold D and d_valid stable while d_valid = 1 and d_ready = 0.
REQ-021 SHALL ignore valid while in_ready = 0 (no overwrite, no drop of stored entries).
REQ-022 SHALL increment count by 1 on each pop and saturate at 2^CNT_W-1 with no wrap.
REQ-023 SHALL never reorder, duplicate or lose entries.

Reset
REQ-024 SHALL, while rst = 1, force state EMPTY, D = 4'b0000, d_valid = 0, in_ready = 0 and count = 0, asynchronously.
REQ-025 SHALL discard buffered entries when rst asserts mid-operation.
REQ-026 SHALL accept the first push in the first cycle after rst deasserts, with in_ready = 1.

Structure
REQ-027 SHALL place the state enum (EMPTY/ONE/TWO), FIFO depth constant 2 and the code-to-one-hot function in shared package priority_pkg.
REQ-028 SHALL be a single module with no sub-modules; the FIFO is two registers plus read/write pointers.

Verification
REQ-029 Reset then Y=0, valid=1 one cycle, d_ready=1 -> next cycle D=4'b1000, d_valid=1; then count=1.
REQ-030 Y=0,1,2,3 back-to-back with d_ready=1 -> D=1000, 0100, 0010, 0001 on consecutive cycles; count=4.
REQ-031 d_ready=0, push Y=3 then Y=1 -> in_ready=0, D=4'b0001 held; a third push with Y=2 is ignored; d_ready=1 -> D=0001 then 0100, then d_valid=0, D=0000.
REQ-032 In ONE holding Y=2, push Y=1 with d_ready=1 -> next cycle D=4'b0100, state ONE, count incremented by 1.
REQ-033 Fill to TWO, assert rst mid-cycle -> d_valid=0, D=0000, count=0 immediately; after release in_ready=1 and no stale data appears.
REQ-034 With CNT_W=2, do 5 pops -> count reads 3 and stays 3.
